// File: rtl/clz_norm_pipe_if.sv
// Operand/result bundle for clz_norm_pipe: valid/ready input side carrying data, mode and tag,
// and valid/ready output side carrying count, normalised operand, zero flag and tag.
interface clz_norm_pipe_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TAG_W = 4
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_mode;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    out_count;
   logic [WIDTH-1:0] out_norm;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;

   // Producer/consumer side
   modport master (
      output in_valid, in_data, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_count, out_norm, out_zero, out_tag
   );

   // Pipeline side
   modport slave (
      input  in_valid, in_data, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_count, out_norm, out_zero, out_tag
   );
endinterface

// File: rtl/clz_norm_pipe.sv
// Three-stage leading-zero / redundant-sign counter with left-shift normalisation.
// A single global stall (adv) moves or holds every stage together.
module clz_norm_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TAG_W = 4
) (
   input logic          clk,
   input logic          rst_n,
   clz_norm_pipe_if.slave bus
);
   localparam int unsigned CW    = $clog2(WIDTH + 1);
   localparam int unsigned P     = 1 << CW;
   localparam int unsigned NODES = P / 2;

   logic             adv;
   logic [WIDTH-1:0] search;
   logic [WIDTH-1:0] sign_inv;

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_data_q, s1_data_d;
   logic [WIDTH-1:0] s1_search_q, s1_search_d;
   logic             s1_mode_q, s1_mode_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_data_q, s2_data_d;
   logic             s2_mode_q, s2_mode_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
   logic [CW-1:0]    s2_count_q, s2_count_d;

   logic             out_valid_q, out_valid_d;
   logic [CW-1:0]    out_count_q, out_count_d;
   logic [WIDTH-1:0] out_norm_q, out_norm_d;
   logic             out_zero_q, out_zero_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;

   logic [P-1:0]     pad_vec;
   logic [CW-1:0]    tree_count;
   logic             tree_valid;

   // The single 1 right below the search vector caps an all-zero search at WIDTH.
   always_comb begin
      pad_vec                     = '0;
      pad_vec[P-1 -: WIDTH]       = s1_search_q;
      pad_vec[P-WIDTH-1]          = 1'b1;
   end

   for (genvar l = 0; l < CW; l++) begin : g_lvl
      logic [(NODES>>l)-1:0]      v;
      logic [(NODES>>l)-1:0][l:0] p;
      for (genvar j = 0; j < (NODES >> l); j++) begin : g_node
         if (l == 0) begin : g_leaf
            assign v[j] = pad_vec[2*j+1] | pad_vec[2*j];
            assign p[j] = ~pad_vec[2*j+1];
         end else begin : g_merge
            assign v[j] = g_lvl[l-1].v[2*j+1] | g_lvl[l-1].v[2*j];
            assign p[j] = g_lvl[l-1].v[2*j+1] ? {1'b0, g_lvl[l-1].p[2*j+1]}
                                              : {1'b1, g_lvl[l-1].p[2*j]};
         end
      end
   end

   assign tree_valid = g_lvl[CW-1].v[0];
   assign tree_count = g_lvl[CW-1].p[0];

   always_comb begin
      adv      = bus.out_ready | ~out_valid_q;
      sign_inv = bus.in_data ^ {WIDTH{bus.in_data[WIDTH-1]}};
      search   = bus.in_mode ? {sign_inv[WIDTH-2:0], 1'b1} : bus.in_data;

      s1_valid_d  = s1_valid_q;
      s1_data_d   = s1_data_q;
      s1_search_d = s1_search_q;
      s1_mode_d   = s1_mode_q;
      s1_tag_d    = s1_tag_q;
      s2_valid_d  = s2_valid_q;
      s2_data_d   = s2_data_q;
      s2_mode_d   = s2_mode_q;
      s2_tag_d    = s2_tag_q;
      s2_count_d  = s2_count_q;
      out_valid_d = out_valid_q;
      out_count_d = out_count_q;
      out_norm_d  = out_norm_q;
      out_zero_d  = out_zero_q;
      out_tag_d   = out_tag_q;

      if (adv) begin
         s1_valid_d  = bus.in_valid;
         s1_data_d   = bus.in_data;
         s1_search_d = search;
         s1_mode_d   = bus.in_mode;
         s1_tag_d    = bus.in_tag;

         s2_valid_d  = s1_valid_q;
         s2_data_d   = s1_data_q;
         s2_mode_d   = s1_mode_q;
         s2_tag_d    = s1_tag_q;
         // tree_valid is always set by the pad bit; the fallback is never taken
         s2_count_d  = tree_valid ? tree_count : CW'(WIDTH);

         out_valid_d = s2_valid_q;
         out_count_d = s2_count_q;
         out_norm_d  = s2_data_q << s2_count_q;
         out_zero_d  = s2_mode_q ? ((&s2_data_q) | ~(|s2_data_q)) : ~(|s2_data_q);
         out_tag_d   = s2_tag_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_search_q <= '0;
         s1_mode_q   <= 1'b0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_data_q   <= '0;
         s2_mode_q   <= 1'b0;
         s2_tag_q    <= '0;
         s2_count_q  <= '0;
         out_valid_q <= 1'b0;
         out_count_q <= '0;
         out_norm_q  <= '0;
         out_zero_q  <= 1'b0;
         out_tag_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_search_q <= s1_search_d;
         s1_mode_q   <= s1_mode_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         s2_data_q   <= s2_data_d;
         s2_mode_q   <= s2_mode_d;
         s2_tag_q    <= s2_tag_d;
         s2_count_q  <= s2_count_d;
         out_valid_q <= out_valid_d;
         out_count_q <= out_count_d;
         out_norm_q  <= out_norm_d;
         out_zero_q  <= out_zero_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.out_count = out_count_q;
   assign bus.out_norm  = out_norm_q;
   assign bus.out_zero  = out_zero_q;
   assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_clz_norm_pipe.sv
// Scoreboard bench: WIDTH 8 and WIDTH 5 instances share one random stimulus stream;
// expected results come from a bit-scanning reference model and are checked on retirement.
module tb_clz_norm_pipe;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_mode = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = '0;
   logic [3:0] in_tag = '0;

   always #5 clk = ~clk;

   clz_norm_pipe_if #(.WIDTH(8), .TAG_W(4)) bus8 ();
   clz_norm_pipe_if #(.WIDTH(5), .TAG_W(4)) bus5 ();

   assign bus8.in_valid  = in_valid;
   assign bus8.in_data   = in_data;
   assign bus8.in_mode   = in_mode;
   assign bus8.in_tag    = in_tag;
   assign bus8.out_ready = out_ready;
   assign bus5.in_valid  = in_valid;
   assign bus5.in_data   = in_data[4:0];
   assign bus5.in_mode   = in_mode;
   assign bus5.in_tag    = in_tag;
   assign bus5.out_ready = out_ready;

   clz_norm_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   clz_norm_pipe #(.WIDTH(5), .TAG_W(4)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

   typedef struct {
      int         count;
      logic [7:0] norm;
      logic       zero;
      logic [3:0] tag;
      int         exp_cyc;
      int         snap;
   } exp_t;

   exp_t q8[$];
   exp_t q5[$];
   exp_t e8, e5;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   stall8 = 0, stall5 = 0;
   logic was_stall8 = 1'b0, was_stall5 = 1'b0;
   int   prev8 = 0, prev5 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: scan from the MSB; mode 1 counts bits below the MSB that equal it.
   function automatic exp_t model(input logic [7:0] d, input int w, input logic m,
                                  input logic [3:0] tag);
      exp_t       e;
      int         c = 0;
      logic       found = 1'b0;
      logic [7:0] mask = '0;
      logic [7:0] dm;
      for (int i = 0; i < w; i++) mask[i] = 1'b1;
      dm = d & mask;
      if (!m) begin
         for (int i = w - 1; i >= 0; i--) begin
            if (!found && !dm[i]) c++;
            else found = 1'b1;
         end
      end else begin
         for (int i = w - 2; i >= 0; i--) begin
            if (!found && dm[i] == dm[w-1]) c++;
            else found = 1'b1;
         end
      end
      e.count   = c;
      e.norm    = (dm << c) & mask;
      e.zero    = m ? (dm == 8'h00 || dm == mask) : (dm == 8'h00);
      e.tag     = tag;
      e.exp_cyc = 0;
      e.snap    = 0;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out8", {bus8.out_valid, bus8.out_zero, |bus8.out_count, |bus8.out_norm,
                          |bus8.out_tag}, 0);
         chk("rst_out5", {bus5.out_valid, bus5.out_zero, |bus5.out_count, |bus5.out_norm,
                          |bus5.out_tag}, 0);
         q8.delete();
         q5.delete();
         was_stall8 = 1'b0;
         was_stall5 = 1'b0;
      end else begin
         // WIDTH 8 instance
         if (bus8.out_valid && out_ready) begin
            if (q8.size() == 0) chk("unexpected8", 1, 0);
            else begin
               e8 = q8.pop_front();
               chk("count8", int'(bus8.out_count), e8.count);
               chk("norm8", int'(bus8.out_norm), int'(e8.norm));
               chk("zero8", int'(bus8.out_zero), int'(e8.zero));
               chk("tag8", int'(bus8.out_tag), int'(e8.tag));
               chk("latency8", cyc, e8.exp_cyc + stall8 - e8.snap);
            end
         end
         if (!bus8.out_valid) chk("empty_ready8", int'(bus8.in_ready), 1);
         if (in_valid && bus8.in_ready) begin
            e8 = model(in_data, 8, in_mode, in_tag);
            e8.exp_cyc = cyc + 3;
            e8.snap = stall8;
            q8.push_back(e8);
         end
         if (bus8.out_valid && !out_ready) begin
            chk("stall_ready8", int'(bus8.in_ready), 0);
            if (was_stall8)
               chk("frozen8", {bus8.out_count, bus8.out_norm, bus8.out_zero, bus8.out_tag}, prev8);
            prev8 = {bus8.out_count, bus8.out_norm, bus8.out_zero, bus8.out_tag};
            stall8++;
            was_stall8 = 1'b1;
         end else was_stall8 = 1'b0;

         // WIDTH 5 instance
         if (bus5.out_valid && out_ready) begin
            if (q5.size() == 0) chk("unexpected5", 1, 0);
            else begin
               e5 = q5.pop_front();
               chk("count5", int'(bus5.out_count), e5.count);
               chk("norm5", int'(bus5.out_norm), int'(e5.norm));
               chk("zero5", int'(bus5.out_zero), int'(e5.zero));
               chk("tag5", int'(bus5.out_tag), int'(e5.tag));
               chk("latency5", cyc, e5.exp_cyc + stall5 - e5.snap);
            end
         end
         if (!bus5.out_valid) chk("empty_ready5", int'(bus5.in_ready), 1);
         if (in_valid && bus5.in_ready) begin
            e5 = model(in_data, 5, in_mode, in_tag);
            e5.exp_cyc = cyc + 3;
            e5.snap = stall5;
            q5.push_back(e5);
         end
         if (bus5.out_valid && !out_ready) begin
            chk("stall_ready5", int'(bus5.in_ready), 0);
            if (was_stall5)
               chk("frozen5", {bus5.out_count, bus5.out_norm, bus5.out_zero, bus5.out_tag}, prev5);
            prev5 = {bus5.out_count, bus5.out_norm, bus5.out_zero, bus5.out_tag};
            stall5++;
            was_stall5 = 1'b1;
         end else was_stall5 = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] dir_data [8] = '{8'h10, 8'h00, 8'hF4, 8'hFF, 8'h00, 8'h40, 8'h01, 8'h80};
   logic       dir_mode [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Directed operands back-to-back, tags 0..7
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = dir_data[i];
         in_mode  = dir_mode[i];
         in_tag   = 4'(i);
         tick();
      end
      in_valid = 1'b0;
      repeat (5) tick();

      // Random traffic with a forced 4-cycle backpressure window
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         in_mode   = 1'($urandom);
         in_tag    = 4'($urandom);
         out_ready = (i >= 100 && i < 104) ? 1'b0 : ($urandom_range(0, 4) != 0);
         tick();
      end

      // Reset with operands in flight, then one fresh operand
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         in_mode  = 1'($urandom);
         in_tag   = 4'(10 + i);
         tick();
      end
      rst_n = 1'b0;
      in_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h10;
      in_mode  = 1'b0;
      in_tag   = 4'd9;
      tick();
      in_valid = 1'b0;

      for (int i = 0; i < 40; i++) begin
         if (q8.size() == 0 && q5.size() == 0) break;
         tick();
      end
      chk("drain8", q8.size(), 0);
      chk("drain5", q5.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
